// File: rtl/uba_rdresp.sv
// UBA register read responder: decodes IO reads of the paging RAM, UBASR and UBAMR
// and returns the word with a one-cycle acknowledge. Option macro: UBAMR_RDBK_EN.
module uba_rdresp #(
   parameter logic [0:3]  ubaNUM  = 4'd3,
   parameter logic [0:17] ubaBASE = 18'o763000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        busREQI,
   input  logic        busREADI,
   input  logic        busIOI,
   input  logic [0:35] busADDRI,
   input  logic [0:35] regUBASR,
   input  logic        regUBAMR,
   input  logic [0:35] pageDATA,
   output logic [0:5]  pageADDR,
   output logic        busACKO,
   output logic [0:35] busDATAO,
   output logic        busy
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RAMWT = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;

   localparam logic [1:0] SEL_PAGE = 2'd0;
   localparam logic [1:0] SEL_SR   = 2'd1;
   localparam logic [1:0] SEL_MR   = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [0:5]  page_addr_q, page_addr_d;
   logic        ack_q, ack_d;
   logic        busy_q, busy_d;

   logic [0:17] reg_off_s;
   logic        bus_rd_s;
   logic        hit_page_s;
   logic        hit_sr_s;
   logic        hit_mr_s;
   logic [0:35] mr_word_s;
   logic        unused_s;

   // Offset from the register page base; paging occupies offsets 0..077.
   assign reg_off_s = busADDRI[18:35] - ubaBASE;

   // Address decode of an IO read aimed at this bridge.
   always_comb begin
      bus_rd_s   = busREQI & busREADI & busIOI & (busADDRI[14:17] == ubaNUM);
      hit_page_s = bus_rd_s & (reg_off_s < 18'o000100);
      hit_sr_s   = bus_rd_s & (reg_off_s == 18'o000100);
      hit_mr_s   = bus_rd_s & (reg_off_s == 18'o000101);
   end

`ifdef UBAMR_RDBK_EN
   // MR diagnostic readback: CR bit in bit 35.
   assign mr_word_s = {35'b0, regUBAMR};
   assign unused_s  = ^busADDRI[0:13];
`else
   // CR always reads back as zero on this hardware.
   assign mr_word_s = 36'b0;
   assign unused_s  = ^{busADDRI[0:13], regUBAMR};
`endif

   // Next-state logic; requests seen outside IDLE are dropped.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      page_addr_d = page_addr_q;
      ack_d       = 1'b0;
      busy_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hit_page_s) begin
               state_d     = ST_RAMWT;
               sel_d       = SEL_PAGE;
               page_addr_d = busADDRI[30:35];
               busy_d      = 1'b1;
            end else if (hit_sr_s || hit_mr_s) begin
               state_d     = ST_ACK;
               sel_d       = hit_sr_s ? SEL_SR : SEL_MR;
               page_addr_d = busADDRI[30:35];
               ack_d       = 1'b1;
               busy_d      = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RAMWT: begin
            state_d = ST_ACK;
            ack_d   = 1'b1;
            busy_d  = 1'b1;
         end
         ST_ACK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         sel_q       <= SEL_PAGE;
         page_addr_q <= 6'o00;
         ack_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         page_addr_q <= page_addr_d;
         ack_q       <= ack_d;
         busy_q      <= busy_d;
      end
   end

   // Read data is steered by registered ack/select so SR and RAM words are current in the ACK cycle.
   always_comb begin
      busDATAO = 36'b0;
      if (ack_q) begin
         case (sel_q)
            SEL_PAGE: busDATAO = pageDATA;
            SEL_SR:   busDATAO = regUBASR;
            SEL_MR:   busDATAO = mr_word_s;
            default:  busDATAO = 36'b0;
         endcase
      end else begin
         busDATAO = 36'b0;
      end
   end

   assign pageADDR = page_addr_q;
   assign busACKO  = ack_q;
   assign busy     = busy_q;

endmodule
